// File: rtl/cmp_branch_resolver_if.sv
// Branch request / result handshake bundle between the issuing stage
// and the branch resolver.
interface cmp_branch_resolver_if #(
  parameter int ADDR_W = 10
);
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_off;
  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;

  modport master (
    output br_valid, br_cond, br_pc, br_off, res_ready,
    input  br_ready, res_valid, res_taken, res_target
  );

  modport slave (
    input  br_valid, br_cond, br_pc, br_off, res_ready,
    output br_ready, res_valid, res_taken, res_target
  );
endinterface

// File: rtl/cmp_branch_resolver.sv
// Latches comparator flags and resolves branch requests against them,
// producing taken/next-PC one cycle after acceptance.
module cmp_branch_resolver #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flag_we,
  input  logic                 above,
  input  logic                 equal,
  input  logic                 below,
  cmp_branch_resolver_if.slave br,
  output logic [2:0]           flags_q,
  output logic                 flag_err,
  output logic [CNT_W-1:0]     taken_cnt
);

  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;
  logic [ADDR_W-1:0] res_target_q, res_target_d;
  logic [2:0]        flags_d;
  logic              flag_err_q, flag_err_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
  logic [2:0]        eff;
  logic              cond_ok;
  logic              accept;
  logic              in_onehot;

  assign br.br_ready  = !res_valid_q || br.res_ready;
  assign br.res_valid = res_valid_q;
  assign br.res_taken = res_taken_q;
  assign br.res_target = res_target_q;
  assign flag_err     = flag_err_q;
  assign taken_cnt    = taken_cnt_q;

  assign accept = br.br_valid && br.br_ready;

  always_comb begin
    // Forward incoming flags so a same-cycle compare never goes stale.
    eff     = flag_we ? {above, equal, below} : flags_q;
    cond_ok = 1'b0;
    unique case (br.br_cond)
      3'b000: cond_ok = 1'b1;
      3'b001: cond_ok = eff[1];
      3'b010: cond_ok = eff[2] | eff[0];
      3'b011: cond_ok = eff[2];
      3'b100: cond_ok = eff[0];
      3'b101: cond_ok = eff[2] | eff[1];
      3'b110: cond_ok = eff[0] | eff[1];
      3'b111: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    in_onehot = ({above, equal, below} == 3'b100)
             || ({above, equal, below} == 3'b010)
             || ({above, equal, below} == 3'b001);
    flags_d    = flags_q;
    flag_err_d = flag_err_q;
    if (flag_we) begin
      flags_d    = {above, equal, below};
      flag_err_d = flag_err_q | !in_onehot;
    end
  end

  always_comb begin
    res_valid_d  = res_valid_q;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    taken_cnt_d  = taken_cnt_q;
    if (accept) begin
      res_valid_d  = 1'b1;
      res_taken_d  = cond_ok;
      res_target_d = br.br_pc + ADDR_W'(1)
                   + (cond_ok ? br.br_off : '0);
      if (cond_ok && taken_cnt_q != '1)
        taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end else if (br.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= '0;
      flag_err_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      flags_q      <= flags_d;
      flag_err_q   <= flag_err_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_cmp_branch_resolver.sv
// Directed bench for cmp_branch_resolver; a second CNT_W=2 copy
// shadows the stimulus to exercise counter saturation.
module tb_cmp_branch_resolver;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  logic flag_we, above, equal, below;
  logic [2:0]  flags_q, s_flags;
  logic        flag_err, s_err;
  logic [15:0] taken_cnt;
  logic [1:0]  s_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_branch_resolver_if #(.ADDR_W(AW)) bi ();
  cmp_branch_resolver_if #(.ADDR_W(AW)) si ();

  assign si.br_valid  = bi.br_valid;
  assign si.br_cond   = bi.br_cond;
  assign si.br_pc     = bi.br_pc;
  assign si.br_off    = bi.br_off;
  assign si.res_ready = bi.res_ready;

  cmp_branch_resolver #(.ADDR_W(AW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flag_we(flag_we),
    .above(above), .equal(equal), .below(below),
    .br(bi.slave), .flags_q(flags_q),
    .flag_err(flag_err), .taken_cnt(taken_cnt)
  );

  cmp_branch_resolver #(.ADDR_W(AW), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flag_we(flag_we),
    .above(above), .equal(equal), .below(below),
    .br(si.slave), .flags_q(s_flags),
    .flag_err(s_err), .taken_cnt(s_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    flag_we     = 1'b0;
    bi.br_valid = 1'b0;
  endtask

  task automatic fl(input logic a, input logic e, input logic b);
    flag_we = 1'b1;
    above   = a;
    equal   = e;
    below   = b;
  endtask

  task automatic br(input logic [2:0] c,
                    input logic [AW-1:0] pc,
                    input logic [AW-1:0] off);
    bi.br_valid = 1'b1;
    bi.br_cond  = c;
    bi.br_pc    = pc;
    bi.br_off   = off;
  endtask

  initial begin
    rst = 1'b1;
    above = 0; equal = 0; below = 0;
    idle();
    bi.br_cond = 3'b000; bi.br_pc = '0; bi.br_off = '0;
    bi.res_ready = 1'b1;
    step(); step();
    chk("rst_valid",  32'(bi.res_valid), 0);
    chk("rst_taken",  32'(bi.res_taken), 0);
    chk("rst_target", 32'(bi.res_target), 0);
    chk("rst_flags",  32'(flags_q), 0);
    chk("rst_err",    32'(flag_err), 0);
    chk("rst_cnt",    32'(taken_cnt), 0);
    chk("rst_ready",  32'(bi.br_ready), 1);
    rst = 1'b0;

    fl(0, 1, 0); step(); idle();
    chk("eq_flags", 32'(flags_q), 32'h2);
    br(3'b001, 10'h010, 10'h005);
    chk("eq_ready", 32'(bi.br_ready), 1);
    step(); idle();
    chk("eq_valid",  32'(bi.res_valid), 1);
    chk("eq_taken",  32'(bi.res_taken), 1);
    chk("eq_target", 32'(bi.res_target), 32'h016);
    chk("eq_err",    32'(flag_err), 0);
    chk("eq_cnt",    32'(taken_cnt), 1);
    step();
    chk("eq_drain", 32'(bi.res_valid), 0);

    fl(0, 0, 1); step(); idle();
    fl(1, 0, 0); br(3'b100, 10'h020, 10'h005);
    step(); idle();
    chk("fwd_taken",  32'(bi.res_taken), 0);
    chk("fwd_target", 32'(bi.res_target), 32'h021);
    chk("fwd_flags",  32'(flags_q), 32'h4);
    chk("fwd_cnt",    32'(taken_cnt), 1);

    br(3'b000, 10'h3FF, 10'h001); step();
    chk("wrap1_taken",  32'(bi.res_taken), 1);
    chk("wrap1_target", 32'(bi.res_target), 32'h001);
    br(3'b000, 10'h000, 10'h3FE); step();
    chk("wrap2_target", 32'(bi.res_target), 32'h3FF);
    chk("wrap2_valid",  32'(bi.res_valid), 1);
    chk("wrap2_cnt",    32'(taken_cnt), 3);
    br(3'b011, 10'h100, 10'h010); step();
    chk("gt_taken",  32'(bi.res_taken), 1);
    chk("gt_target", 32'(bi.res_target), 32'h111);
    br(3'b110, 10'h100, 10'h010); step();
    chk("le_taken",  32'(bi.res_taken), 0);
    chk("le_target", 32'(bi.res_target), 32'h101);
    br(3'b111, 10'h200, 10'h010); step();
    chk("nv_taken",  32'(bi.res_taken), 0);
    chk("nv_target", 32'(bi.res_target), 32'h201);
    idle(); step();
    chk("idle_valid", 32'(bi.res_valid), 0);
    chk("cnt4",       32'(taken_cnt), 4);
    chk("sat_cnt4",   32'(s_cnt), 3);

    bi.res_ready = 1'b0;
    br(3'b000, 10'h040, 10'h002); step();
    chk("bp1_valid",  32'(bi.res_valid), 1);
    chk("bp1_target", 32'(bi.res_target), 32'h043);
    chk("bp1_ready",  32'(bi.br_ready), 0);
    br(3'b000, 10'h050, 10'h004); step();
    chk("bp_hold_target", 32'(bi.res_target), 32'h043);
    chk("bp_hold_valid",  32'(bi.res_valid), 1);
    chk("bp_hold_cnt",    32'(taken_cnt), 5);
    bi.res_ready = 1'b1; #1;
    chk("bp_ready", 32'(bi.br_ready), 1);
    step(); idle();
    chk("bp2_target", 32'(bi.res_target), 32'h055);
    chk("bp2_valid",  32'(bi.res_valid), 1);
    chk("bp2_cnt",    32'(taken_cnt), 6);
    step();
    chk("bp_drain", 32'(bi.res_valid), 0);

    fl(1, 1, 0); step(); idle();
    chk("err_set",   32'(flag_err), 1);
    chk("err_flags", 32'(flags_q), 32'h6);
    fl(0, 1, 0); step(); idle();
    chk("err_sticky", 32'(flag_err), 1);

    bi.res_ready = 1'b0;
    br(3'b000, 10'h060, 10'h000); step();
    chk("pre_rst_valid", 32'(bi.res_valid), 1);
    rst = 1'b1; step();
    chk("rst2_valid", 32'(bi.res_valid), 0);
    chk("rst2_cnt",   32'(taken_cnt), 0);
    chk("rst2_flags", 32'(flags_q), 0);
    chk("rst2_err",   32'(flag_err), 0);
    chk("rst2_sat",   32'(s_cnt), 0);
    rst = 1'b0; idle(); bi.res_ready = 1'b1;

    br(3'b010, 10'h070, 10'h003); step(); idle();
    chk("ne0_taken",  32'(bi.res_taken), 0);
    chk("ne0_target", 32'(bi.res_target), 32'h071);
    chk("ne0_cnt",    32'(taken_cnt), 0);

    for (int i = 0; i < 5; i++) begin
      br(3'b000, AW'(i), 10'h001);
      step();
    end
    idle();
    chk("sat_target", 32'(bi.res_target), 32'h006);
    chk("cnt5",       32'(taken_cnt), 5);
    chk("sat_cnt5",   32'(s_cnt), 3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
